// File: rtl/alu_pkg.sv
// Opcode constants and small opcode helpers shared by the 16-bit alu and its multi-precision sequencer.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_ADDC = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_SUBB = 3'd3;
  localparam logic [2:0] ALU_MOD  = 3'd4;
  localparam logic [2:0] ALU_AND  = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_XOR  = 3'd7;

  // Upper slices must consume the carry/borrow produced by the slice below.
  function automatic logic [2:0] chain_op(input logic [2:0] op);
    case (op)
      ALU_ADD: chain_op = ALU_ADDC;
      ALU_SUB: chain_op = ALU_SUBB;
      default: chain_op = op;
    endcase
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    is_arith = (op == ALU_ADD) || (op == ALU_ADDC) || (op == ALU_SUB) || (op == ALU_SUBB);
  endfunction

endpackage

// File: rtl/alu.sv
// 16-bit alu with registered result and carry/borrow; one cycle latency, no stall (accepts every cycle).
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  op,
  input  logic        c_in,
  output logic [15:0] y,
  output logic        c_out
);

  logic [15:0] y_d, y_q;
  logic        c_d, c_q;
  logic [16:0] ext;

  always_comb begin
    ext = '0;
    y_d = '0;
    c_d = 1'b0;
    case (op)
      ALU_ADD:  ext = {1'b0, a} + {1'b0, b};
      ALU_ADDC: ext = {1'b0, a} + {1'b0, b} + {16'b0, c_in};
      ALU_SUB:  ext = {1'b0, a} - {1'b0, b};
      ALU_SUBB: ext = {1'b0, a} - {1'b0, b} - {16'b0, c_in};
      default:  ext = '0;
    endcase
    case (op)
      ALU_MOD: y_d = (b == 16'd0) ? 16'd0 : (a % b);
      ALU_AND: y_d = a & b;
      ALU_OR:  y_d = a | b;
      ALU_XOR: y_d = a ^ b;
      default: begin
        y_d = ext[15:0];
        c_d = ext[16];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
      c_q <= 1'b0;
    end else begin
      y_q <= y_d;
      c_q <= c_d;
    end
  end

  assign y     = y_q;
  assign c_out = c_q;

endmodule

// File: rtl/mp_alu_seq.sv
// Multi-precision sequencer: walks WORDS 16-bit slices through the shared alu, LS slice first.
// done WORDS+1 edges after accept; start is dropped (not queued) while busy.
module mp_alu_seq
  import alu_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WORDS*16-1:0] a_in,
  input  logic [WORDS*16-1:0] b_in,
  input  logic               c_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WORDS*16-1:0] result,
  output logic               carry_out,
  output logic [15:0]        alu_a,
  output logic [15:0]        alu_b,
  output logic [2:0]         alu_op,
  output logic               alu_c_in,
  input  logic [15:0]        alu_out,
  input  logic               alu_c_out
);

  localparam int W  = WORDS * 16;
  localparam int CW = $clog2(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]      op_q, op_d;
  logic            cin_q, cin_d, busy_q, busy_d, done_q, done_d;
  logic            err_q, err_d, carry_q, carry_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cin_d    = cin_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    carry_d  = carry_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a_in;
          b_d   = b_in;
          op_d  = op;
          cin_d = c_in;
          cnt_d = '0;
          err_d = 1'b0;
          // The modulo opcode has no multi-precision meaning: reject on the accept edge without touching the alu.
          if (op == ALU_MOD) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        for (int k = 1; k < WORDS; k++) begin
          if (cnt_q == CW'(k)) result_d[16*(k-1) +: 16] = alu_out;
        end
        if (cnt_q == CW'(WORDS - 1)) state_d = S_DRAIN;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      S_DRAIN: begin
        result_d[W-16 +: 16] = alu_out;
        carry_d = is_arith(op_q) ? alu_c_out : 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slice mux to the alu; carry chains combinationally from the alu's registered carry.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    alu_c_in = 1'b0;
    if (state_q == S_RUN) begin
      for (int k = 0; k < WORDS; k++) begin
        if (cnt_q == CW'(k)) begin
          alu_a = a_q[16*k +: 16];
          alu_b = b_q[16*k +: 16];
        end
      end
      alu_op   = (cnt_q == '0) ? op_q  : chain_op(op_q);
      alu_c_in = (cnt_q == '0) ? cin_q : alu_c_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_mp_alu_seq.sv
// Bench for mp_alu_seq (WORDS=2) paired with the alu; random ops checked against a wide-arithmetic model.
module tb_mp_alu_seq;
  import alu_pkg::*;

  localparam int WORDS = 2;
  localparam int W     = WORDS * 16;

  logic         clk = 1'b0;
  logic         rst, start, c_in;
  logic [2:0]   op;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, err, carry_out;
  logic [W-1:0] result;
  logic [15:0]  alu_a, alu_b, alu_out;
  logic [2:0]   alu_op;
  logic         alu_c_in, alu_c_out;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_res = '0;
  logic         exp_cy  = 1'b0;

  always #5 clk = ~clk;

  mp_alu_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .busy(busy), .done(done), .err(err), .result(result), .carry_out(carry_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c_in(alu_c_in),
    .alu_out(alu_out), .alu_c_out(alu_c_out)
  );

  alu u_alu (
    .clk(clk), .rst(rst), .a(alu_a), .b(alu_b), .op(alu_op), .c_in(alu_c_in),
    .y(alu_out), .c_out(alu_c_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-operand reference: {carry/borrow, result} computed on 64-bit integers.
  function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    logic [63:0] ua, ub, s;
    ua = 64'(a);
    ub = 64'(b);
    s  = '0;
    case (o)
      ALU_ADD:  begin s = ua + ub;          return {s[W], s[W-1:0]}; end
      ALU_ADDC: begin s = ua + ub + 64'(c); return {s[W], s[W-1:0]}; end
      ALU_SUB:  begin s = ua - ub;          return {ua < ub, s[W-1:0]}; end
      ALU_SUBB: begin s = ua - ub - 64'(c); return {ua < (ub + 64'(c)), s[W-1:0]}; end
      ALU_AND:  return {1'b0, a & b};
      ALU_OR:   return {1'b0, a | b};
      ALU_XOR:  return {1'b0, a ^ b};
      default:  return '0;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c);
    logic [W:0]  m;
    logic [2:0]  upper_op;
    int          n;
    op = o; a_in = a; b_in = b; c_in = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    c_in  = ~c;
    upper_op = (o == ALU_ADD) ? ALU_ADDC : (o == ALU_SUB) ? ALU_SUBB : o;
    if (o != ALU_MOD) begin
      check({tag, "/busy"}, 64'(busy), 64'd1);
      check({tag, "/op0"}, 64'(alu_op), 64'(o));
      check({tag, "/a0"}, 64'(alu_a), 64'(a[15:0]));
      check({tag, "/cin0"}, 64'(alu_c_in), 64'(c));
    end
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && o != ALU_MOD) begin
        check({tag, "/op1"}, 64'(alu_op), 64'(upper_op));
        check({tag, "/b1"}, 64'(alu_b), 64'(b[31:16]));
      end
    end
    check({tag, "/latency"}, 64'(n), (o == ALU_MOD) ? 64'd0 : 64'(WORDS + 1));
    if (o == ALU_MOD) begin
      check({tag, "/err"}, 64'(err), 64'd1);
    end else begin
      m = model(o, a, b, c);
      exp_res = m[W-1:0];
      exp_cy  = m[W];
      check({tag, "/err"}, 64'(err), 64'd0);
    end
    check({tag, "/result"}, 64'(result), 64'(exp_res));
    check({tag, "/carry"}, 64'(carry_out), 64'(exp_cy));
    check({tag, "/busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] acc_a, acc_b;
    logic [2:0]   acc_op;
    logic         acc_c;
    logic [W:0]   m;
    int           dones, errs;

    rst = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/done", 64'(done), 64'd0);
    check("rst/err", 64'(err), 64'd0);
    check("rst/result", 64'(result), 64'd0);
    check("rst/carry", 64'(carry_out), 64'd0);
    check("rst/alu", 64'({alu_a, alu_b, alu_op, alu_c_in}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_ripple", ALU_ADD, 32'h0000FFFF, 32'h00000001, 1'b0);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
    run_op("add_wrap", ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_op("addc_cin", ALU_ADDC, 32'h0, 32'h0, 1'b1);
    run_op("sub_borrow_mid", ALU_SUB, 32'h00010000, 32'h00000001, 1'b0);
    run_op("sub_under", ALU_SUB, 32'h0, 32'h1, 1'b0);
    run_op("xor", ALU_XOR, 32'h12345678, 32'hFFFF0000, 1'b0);
    run_op("mod_reject", ALU_MOD, 32'h1234, 32'h7, 1'b0);
    run_op("subb_eq", ALU_SUBB, 32'h5, 32'h5, 1'b1);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      run_op($sformatf("rand%0d", i), ro, W'($urandom), (i % 5 == 0) ? W'($urandom_range(0, 3)) : W'($urandom),
             1'($urandom));
    end

    // Reset while RUN is on its second slice.
    op = ALU_ADD; a_in = 32'h0001FFFF; b_in = 32'h00000001; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_res = '0;
    exp_cy  = 1'b0;
    check("abort/busy", 64'(busy), 64'd0);
    check("abort/result", 64'(result), 64'd0);
    check("abort/carry", 64'(carry_out), 64'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("abort/no_done", 64'(dones), 64'd0);
    run_op("after_abort", ALU_ADD, 32'h1, 32'h1, 1'b0);

    // start held for 20 edges: acceptance only on every (WORDS+2)th edge, changing operands otherwise ignored.
    dones = 0; errs = 0;
    acc_a = '0; acc_b = '0; acc_op = ALU_ADD; acc_c = 1'b0;
    start = 1'b1;
    for (int e = 0; e < 20; e++) begin
      op   = 3'($urandom_range(0, 3));
      a_in = W'($urandom);
      b_in = W'($urandom);
      c_in = 1'($urandom);
      if (e % (WORDS + 2) == 0) begin
        acc_op = op; acc_a = a_in; acc_b = b_in; acc_c = c_in;
      end
      @(posedge clk); #1;
      if (done) dones++;
      if (err) errs++;
      if (e % (WORDS + 2) == WORDS + 1) begin
        m = model(acc_op, acc_a, acc_b, acc_c);
        check($sformatf("held%0d/done", e), 64'(done), 64'd1);
        check($sformatf("held%0d/result", e), 64'(result), 64'(m[W-1:0]));
        check($sformatf("held%0d/carry", e), 64'(carry_out), 64'(m[W]));
      end
    end
    start = 1'b0;
    check("held/done_count", 64'(dones), 64'd5);
    check("held/err_count", 64'(errs), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
